// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage and its bench.
package rv32i_pkg;
   localparam int          RV32I_XLEN = 32;
   localparam logic [31:0] RV32I_NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      MISS  = 2'd1,
      TRAP  = 2'd2
   } if_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, EX redirect, decode stall, IF/ID outputs.
// master = fetch unit, slave = memory/pipeline environment.
interface instr_fetch_unit_if;
   import rv32i_pkg::*;

   logic [RV32I_XLEN-1:0] imem_addr_o;
   logic [RV32I_XLEN-1:0] imem_instr_i;
   logic                  imem_hit_i;
   logic                  stall_i;
   logic                  redirect_i;
   logic [RV32I_XLEN-1:0] redirect_pc_i;
   logic                  if_valid_o;
   logic [RV32I_XLEN-1:0] if_pc_o;
   logic [RV32I_XLEN-1:0] if_instr_o;
   logic                  misalign_o;
   if_state_t             fetch_state;

   modport master (
      output imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o, fetch_state,
      input  imem_instr_i, imem_hit_i, stall_i, redirect_i, redirect_pc_i
   );

   modport slave (
      input  imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o, fetch_state,
      output imem_instr_i, imem_hit_i, stall_i, redirect_i, redirect_pc_i
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: 1-cycle fetch latency, 1 instr/cycle; stall holds IF/ID and PC,
// redirect flushes (even under stall), misaligned redirect traps until reset.
module instr_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   instr_fetch_unit_if.master  bus
);

   if_state_t             state_q, state_d;
   logic [RV32I_XLEN-1:0] pc_q, pc_d;
   logic                  if_valid_q;
   logic [RV32I_XLEN-1:0] if_pc_q;
   logic [RV32I_XLEN-1:0] if_instr_q;
   logic                  misalign_q;
   logic                  capture;
   logic                  flush;
   logic                  set_trap;

   // Priority: TRAP > redirect > stall > hit/miss; reset is handled in the registers.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      capture  = 1'b0;
      flush    = 1'b0;
      set_trap = 1'b0;
      if (state_q == TRAP) begin
         state_d = TRAP;
      end else if (bus.redirect_i) begin
         pc_d  = bus.redirect_pc_i;
         flush = 1'b1;
         if (bus.redirect_pc_i[1:0] != 2'b00) begin
            set_trap = 1'b1;
            state_d  = TRAP;
         end else begin
            state_d = FETCH;
         end
      end else if (bus.stall_i) begin
         state_d = state_q;
      end else if (bus.imem_hit_i) begin
         capture = 1'b1;
         pc_d    = pc_q + 32'd4;
         state_d = FETCH;
      end else begin
         flush   = 1'b1;
         state_d = MISS;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= RV32I_NOP;
      end else if (capture) begin
         if_valid_q <= 1'b1;
         if_pc_q    <= pc_q;
         if_instr_q <= bus.imem_instr_i;
      end else if (flush) begin
         if_valid_q <= 1'b0;
         if_instr_q <= RV32I_NOP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= FETCH;
         misalign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (set_trap) begin
            misalign_q <= 1'b1;
         end
      end
   end

   assign bus.imem_addr_o = pc_q;
   assign bus.if_valid_o  = if_valid_q;
   assign bus.if_pc_o     = if_pc_q;
   assign bus.if_instr_o  = if_instr_q;
   assign bus.misalign_o  = misalign_q;
   assign bus.fetch_state = state_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RV32I core. Owns the program counter and drives the instruction memory address. Captures the returned word into the IF/ID register, qualified by a valid bit. Handles downstream stalls, branch/jump redirects from EX, memory not-ready (`hit` low), and misaligned redirect targets.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be 4-byte aligned.

Ports:
- `clk_i`  in  1  : single clock, rising edge.
- `rst_i`  in  1  : synchronous, active-high reset.
- `imem_addr_o`  out  32  : fetch address to instruction memory; always equals the internal `pc_q`.
- `imem_instr_i`  in  32  : instruction word from memory, combinational from `imem_addr_o`.
- `imem_hit_i`  in  1  : memory data valid this cycle.
- `stall_i`  in  1  : decode cannot accept; hold the IF/ID register.
- `redirect_i`  in  1  : taken branch/jump; flush and refetch.
- `redirect_pc_i`  in  32  : redirect target.
- `if_valid_o`  out  1  : IF/ID register holds a real instruction.
- `if_pc_o`  out  32  : PC of the held instruction.
- `if_instr_o`  out  32  : held instruction; `32'h0000_0013` (NOP) whenever `if_valid_o`=0.
- `misalign_o`  out  1  : sticky; redirect target had `[1:0]`≠0.

## Operation
- **FSM states:** `FETCH`, `MISS`, `TRAP`. Reset state is `FETCH`.
- **Per-cycle priority** (evaluated at the clock edge): `rst_i` > `TRAP` > `redirect_i` > `stall_i` > `imem_hit_i`.
- **Reset:**
  - `pc_q`=`RESET_PC`, `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=NOP, `misalign_o`=0, state=`FETCH`.
  - Reset asserted mid-operation discards everything, including `TRAP`.
- **Redirect, aligned target:** `pc_q`←`redirect_pc_i`; `if_valid_o`←0 (flush), even if `stall_i`=1; state←`FETCH`.
- **Redirect, misaligned target:**
  - `pc_q`←`redirect_pc_i`, `misalign_o`←1, `if_valid_o`←0, state←`TRAP`.
  - `TRAP` is absorbing until reset: `pc_q` frozen, no captures, outputs held.
- **Stall, no redirect:** `pc_q`, `if_valid_o`, `if_pc_o` and `if_instr_o` all held. `imem_hit_i` is ignored.
- **No stall, `imem_hit_i`=1:**
  - `if_instr_o`←`imem_instr_i`, `if_pc_o`←`pc_q`, `if_valid_o`←1.
  - `pc_q`←`pc_q`+4, modulo 2^32: `32'hFFFF_FFFC` wraps to 0 with no flag.
  - State←`FETCH`.
- **No stall, `imem_hit_i`=0:** `if_valid_o`←0, `if_instr_o`←NOP, `pc_q` held, state←`MISS`. `MISS` behaves like `FETCH`; the state exists only for debug/observability.
- **Redirect with hit in the same cycle:** the memory word is discarded; the redirect wins.
- **Arithmetic:** all PC arithmetic is 32-bit unsigned and truncating. The `[1:0]` bits of `pc_q` are 0 except in `TRAP`.

## Timing
- Fetch latency is 1 cycle: the word at `imem_addr_o` in cycle N appears on `if_instr_o` in cycle N+1.
- Throughput is 1 instruction/cycle with hit=1 and no stall.
- Redirect penalty: the cycle after the redirect edge presents the target on `imem_addr_o` with `if_valid_o`=0. The first target instruction is valid one cycle later.
- `imem_addr_o` is a pure register output with no combinational path from any input.
- `stall_i` and `redirect_i` are sampled only at the clock edge.

## Structure
- Shared package `rv32i_pkg`:
  - `RV32I_NOP` = `32'h0000_0013`
  - `RV32I_XLEN` = 32
  - fetch-state typedef `if_state_t` {`FETCH`, `MISS`, `TRAP`}
- Single module; no sub-module needed. The PC register and the IF/ID register are in one always block each. Next-PC and state logic is combinational.

## Test plan
- **Reset:** `RESET_PC`=0x100, `rst_i` for 2 cycles, then hit=1 with no stall.
  - Required: `imem_addr_o` = 0x100, 0x104, 0x108.
  - Required: `if_pc_o` lags by one cycle with `if_valid_o`=1 from the second cycle after release.
  - Required: all reset values as listed above.
- **Stall:** stream from 0x0; hold `stall_i`=1 for 3 cycles while `if_pc_o`=0x8.
  - Required: `if_pc_o`/`if_instr_o` hold 0x8 and its word; `imem_addr_o` holds 0xC.
  - Required: on release, 0xC is captured next.
- **Redirect during stall:** `stall_i`=1 with `redirect_i`=1 and target 0x40.
  - Required: next cycle `if_valid_o`=0, `if_instr_o`=NOP, `imem_addr_o`=0x40.
  - Required: after release, `if_pc_o`=0x40 is valid.
- **Miss:** hold `imem_hit_i`=0 for 2 cycles at PC 0x20.
  - Required: `if_valid_o`=0, state=`MISS`, `imem_addr_o` stays 0x20.
  - Required: hit=1 then captures 0x20 with valid=1.
- **Misaligned redirect:** `redirect_pc_i`=0x42.
  - Required: `misalign_o`=1 and stays 1, `imem_addr_o`=0x42 frozen, `if_valid_o`=0 forever.
  - Required: `rst_i` clears everything back to `RESET_PC`.
- **Wrap:** redirect to 0xFFFF_FFFC, then hit=1.
  - Required: `imem_addr_o` goes to 0x0 next; `if_pc_o`=0xFFFF_FFFC valid; no flag raised.
